// File: rtl/matrix_mult_udiv_28ns_14ns_seq.sv
// Sequential restoring divider: one quotient bit per enabled cycle, MSB first.
// Divide-by-zero bypasses the iteration and returns all-ones with the low dividend bits as remainder.
//
// state | meaning
// IDLE  | ready for a new operand pair
// CALC  | iterating, one restoring step per ce-high cycle
// DONE  | load result registers, pulse done, return to IDLE
module matrix_mult_udiv_28ns_14ns_seq #(
  parameter int din0_WIDTH = 28,
  parameter int din1_WIDTH = 14,
  parameter int dout_WIDTH = 28
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  ready,
  output logic                  done,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  div_zero
);

  localparam int CW = (din0_WIDTH > 1) ? $clog2(din0_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(din0_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [din0_WIDTH-1:0] quo;   // dividend shifts out of the top, quotient fills the bottom
  logic [din1_WIDTH-1:0] part;
  logic [din1_WIDTH-1:0] dsr;
  logic                  dz;

  logic [din1_WIDTH:0]   shifted;
  logic                  ge;
  logic [din1_WIDTH-1:0] step_rem;

  // Partial remainder is always < divisor, so the narrow modular difference is exact when ge.
  always_comb begin
    shifted  = {part, quo[din0_WIDTH-1]};
    ge       = (shifted >= {1'b0, dsr});
    step_rem = ge ? (shifted[din1_WIDTH-1:0] - dsr) : shifted[din1_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      quo      <= '0;
      part     <= '0;
      dsr      <= '0;
      dz       <= 1'b0;
      ready    <= 1'b1;
      done     <= 1'b0;
      dout     <= '0;
      rem      <= '0;
      div_zero <= 1'b0;
    end else if (ce) begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            quo   <= din0;
            dsr   <= din1;
            part  <= '0;
            cnt   <= CNT_LAST;
            ready <= 1'b0;
            if (din1 == '0) begin
              dz    <= 1'b1;
              state <= DONE;
            end else begin
              dz    <= 1'b0;
              state <= CALC;
            end
          end
        end
        CALC: begin
          quo  <= {quo[din0_WIDTH-2:0], ge};
          part <= step_rem;
          if (cnt == '0) state <= DONE;
          else           cnt   <= cnt - 1'b1;
        end
        DONE: begin
          done     <= 1'b1;
          dout     <= dz ? '1 : quo;
          rem      <= dz ? quo[din1_WIDTH-1:0] : part;
          div_zero <= dz;
          ready    <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/matrix_mult_udiv_28ns_14ns_seq.md
MATRIX_MULT_UDIV_28NS_14NS_SEQ -- requirements
Module: matrix_mult_udiv_28ns_14ns_seq

Interface
REQ-001 Parameter din0_WIDTH, default 28, dividend width.
REQ-002 Parameter din1_WIDTH, default 14, divisor width.
REQ-003 Parameter dout_WIDTH, default 28, quotient width; SHALL equal din0_WIDTH.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 ce  input  1  clock enable; SHALL freeze all state when low.
REQ-007 start  input  1  request; SHALL be sampled only when ready=1 and ce=1.
REQ-008 din0  input  din0_WIDTH  unsigned dividend; SHALL be captured on the accepted start.
REQ-009 din1  input  din1_WIDTH  unsigned divisor; SHALL be captured on the accepted start.
REQ-010 ready  output  1  high in IDLE only.
REQ-011 done  output  1  one-cycle pulse when the result registers update.
REQ-012 dout  output  dout_WIDTH  quotient; SHALL hold until the next done.
REQ-013 rem  output  din1_WIDTH  remainder; SHALL hold until the next done.
REQ-014 div_zero  output  1  high with the result when the captured divisor was 0; SHALL hold until the next done.

Function
REQ-015 The block SHALL implement an FSM with states IDLE, CALC and DONE.
REQ-016 IDLE SHALL go to CALC on an accepted start with a nonzero divisor, and to DONE with a zero divisor.
REQ-017 CALC SHALL perform one restoring-division step per ce-high cycle, MSB first, for exactly din0_WIDTH steps, then go to DONE.
REQ-018 Each step SHALL shift the partial remainder left (din1_WIDTH+1 bits) with the next dividend bit in.
REQ-019 Each step SHALL subtract the divisor if the partial remainder is >= the divisor, and shift the comparison result into the quotient LSB.
REQ-020 A step counter SHALL count din0_WIDTH-1 down to 0; CALC SHALL exit when it is 0 and ce=1.
REQ-021 DONE SHALL last one ce-high cycle with done=1, load dout/rem/div_zero, and return to IDLE.
REQ-022 Latency: with start accepted at edge T and ce constantly high, done SHALL be high in the cycle after edge T+din0_WIDTH+1 (T+29 at defaults).
REQ-023 Zero-divisor latency: done SHALL be high in the cycle after edge T+1.
REQ-024 Zero-divisor result: dout=all ones, rem=din0[din1_WIDTH-1:0], div_zero=1.
REQ-025 Nonzero-divisor result: div_zero=0; dout*din1+rem SHALL equal din0, and rem SHALL be < din1.
REQ-026 start while ready=0 SHALL be ignored; the in-flight operation SHALL be unaffected.
REQ-027 Changing din0/din1 after acceptance SHALL not affect the result.
REQ-028 ce=0 in any state SHALL hold state, counter, datapath and outputs; done SHALL stay high while DONE is stalled.
REQ-029 Each ce-low cycle SHALL extend latency by exactly one cycle.
REQ-030 start=1 held continuously SHALL accept the next operation on the first IDLE cycle after DONE (back-to-back throughput din0_WIDTH+2 cycles).

Reset
REQ-031 reset=1 at a rising edge SHALL force IDLE regardless of ce.
REQ-032 On reset: ready=1, done=0, dout=0, rem=0, div_zero=0, counter=0.
REQ-033 Reset mid-CALC or in DONE SHALL abort the operation with no done pulse.
REQ-034 reset SHALL take priority over start in the same cycle.

Verification
REQ-035 din0=1000, din1=7, start at T, ce=1 -> done after T+29, dout=142, rem=6, div_zero=0.
REQ-036 din0=0xFFFFFFF, din1=1 -> dout=0xFFFFFFF, rem=0; din0=5, din1=0x3FFF -> dout=0, rem=5.
REQ-037 din0=500, din1=0 -> done after T+1, dout=0xFFFFFFF, rem=500, div_zero=1.
REQ-038 1000/7 with ce low for 5 cycles mid-CALC -> done after T+34, same result; a start pulse with din1=3 during CALC is ignored.
REQ-039 reset asserted at T+10 of 1000/7 -> next cycle ready=1, all outputs 0, no done; a new 81/9 then yields dout=9, rem=0.
REQ-040 Random regression: 10,000 operands including din1=0, 1 and max, with random ce gaps -> every result matches the REQ-024/REQ-025 reference model.
